// File: rtl/detector_jogada_pkg.sv
// Shared types and helpers for the player push-button detector.
package detector_jogada_pkg;

  // FSM states; the encoding is exported unchanged on db_estado.
  typedef enum logic [1:0] {
    ESPERA_SOLTA = 2'd0,  // waiting for every button to be released
    OCIOSO       = 2'd1,  // idle, ready for a new press
    FILTRA       = 2'd2,  // debouncing a candidate press
    EMITE        = 2'd3   // one-cycle play strobe
  } estado_t;

  // Widest button vector the one_hot helper accepts.
  localparam int MAX_BOTOES = 32;

  // True when exactly one bit of vec is set.
  function automatic logic one_hot(input logic [MAX_BOTOES-1:0] vec);
    logic [5:0] pop;
    pop = '0;
    for (int i = 0; i < MAX_BOTOES; i++) begin
      pop = pop + 6'(vec[i]);
    end
    return pop == 6'd1;
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Two-flop synchroniser bringing the raw buttons into the clock domain.
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift chain: first stage may go metastable, second stage is the clean copy.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Stage registers, cleared by the synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/detector_jogada.sv
// Push-button conditioner: synchronises, debounces, rejects chords and
// waits for release, producing a one-cycle play strobe and a held one-hot code.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N_BOTOES = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic                fez_jogada,
  output logic [N_BOTOES-1:0] jogada,
  output logic                erro_multipla,
  output logic [1:0]          db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE);

  logic [N_BOTOES-1:0] s;

  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                erro_q, erro_d;

  logic                cnt_max;
  logic                cand_valida;

  sincronizador #(
    .WIDTH (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  assign cnt_max     = (cnt_q == CNT_W'(DEBOUNCE - 1));
  assign cand_valida = one_hot(MAX_BOTOES'(cand_q));

  // Next-state, counter, candidate and registered-output logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    jogada_d = jogada_q;
    erro_d   = 1'b0;

    case (estado_q)
      ESPERA_SOLTA: begin
        // Any pressed button restarts the release filter.
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_max) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      OCIOSO: begin
        // Presses made while disabled stay in s and are picked up once enabled.
        if (habilita && (s != '0)) begin
          cand_d   = s;
          cnt_d    = '0;
          estado_d = FILTRA;
        end
      end

      FILTRA: begin
        if (!habilita || (s != cand_q)) begin
          // Bounce, chord change or loss of enable: restart from idle.
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_max) begin
          cnt_d = '0;
          if (cand_valida) begin
            jogada_d = cand_q;
            estado_d = EMITE;
          end else begin
            erro_d   = 1'b1;
            estado_d = ESPERA_SOLTA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EMITE: begin
        estado_d = ESPERA_SOLTA;
        cnt_d    = '0;
      end

      default: begin
        estado_d = ESPERA_SOLTA;
        cnt_d    = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ESPERA_SOLTA;
      cnt_q    <= '0;
      cand_q   <= '0;
      jogada_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      jogada_q <= jogada_d;
      erro_q   <= erro_d;
    end
  end

  // Moore outputs decoded straight from registers.
  assign fez_jogada    = (estado_q == EMITE);
  assign erro_multipla = erro_q;
  assign jogada        = jogada_q;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed vector table, a bounce sequence and
// randomized traffic, all compared against a run-length reference model.
module tb_detector_jogada;

  localparam int NB = 4;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] botoes;
  logic          habilita;
  logic          fez_jogada;
  logic [NB-1:0] jogada;
  logic          erro_multipla;
  logic [1:0]    db_estado;

  int checks   = 0;
  int failures = 0;

  detector_jogada #(
    .N_BOTOES (NB),
    .DEBOUNCE (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes        (botoes),
    .habilita      (habilita),
    .fez_jogada    (fez_jogada),
    .jogada        (jogada),
    .erro_multipla (erro_multipla),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the synchroniser as a two-sample delay line, the release wait as a
  // count of consecutive zero samples, and the filter as the length of the
  // current run of identical enabled non-zero samples.
  logic [NB-1:0] m_d1, m_d2;
  logic          m_armed;
  int            m_quiet;
  int            m_run;
  logic [NB-1:0] m_val;
  logic [NB-1:0] m_jog;
  logic          m_emit;
  logic          m_err;

  task automatic model_edge(input logic [NB-1:0] b, input logic h, input logic r);
    logic [NB-1:0] sv;
    sv = m_d2;
    if (r) begin
      m_d1 = '0; m_d2 = '0; m_armed = 1'b0; m_quiet = 0; m_run = 0;
      m_val = '0; m_jog = '0; m_emit = 1'b0; m_err = 1'b0;
    end else begin
      m_d2  = m_d1;
      m_d1  = b;
      m_err = 1'b0;
      if (m_emit) begin
        m_emit  = 1'b0;
        m_armed = 1'b0;
        m_quiet = 0;
      end else if (!m_armed) begin
        if (sv == '0) begin
          m_quiet++;
          if (m_quiet == D) begin
            m_armed = 1'b1;
            m_run   = 0;
          end
        end else begin
          m_quiet = 0;
        end
      end else if (m_run == 0) begin
        if (h && sv != '0) begin
          m_run = 1;
          m_val = sv;
        end
      end else if (!h || sv != m_val) begin
        m_run = 0;
      end else if (m_run == D) begin
        m_run = 0;
        if ($countones(m_val) == 1) begin
          m_jog  = m_val;
          m_emit = 1'b1;
        end else begin
          m_err   = 1'b1;
          m_armed = 1'b0;
          m_quiet = 0;
        end
      end else begin
        m_run++;
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_emit)     return 2'd3;
    if (!m_armed)   return 2'd0;
    if (m_run == 0) return 2'd1;
    return 2'd2;
  endfunction

  // One clock: drive, advance model on the edge, compare 1 time unit later.
  task automatic step(input logic [NB-1:0] b, input logic h, input logic r);
    botoes   = b;
    habilita = h;
    reset    = r;
    @(posedge clock);
    model_edge(b, h, r);
    #1;
    check("model_fez", 32'(fez_jogada), 32'(m_emit));
    check("model_erro", 32'(erro_multipla), 32'(m_err));
    check("model_jogada", 32'(jogada), 32'(m_jog));
    check("model_estado", 32'(db_estado), 32'(model_state()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          hab;
    logic [NB-1:0] b;
    int            cyc;
    int            n_fez;
    int            n_err;
    int            first_fez;  // step index of the strobe within the row, -1 = don't care
    logic [NB-1:0] jog;
    logic [1:0]    est;
  } row_t;

  row_t rows[$];

  task automatic apply_row(input row_t r, input int idx);
    int nf, ne, first, hold_bad;
    nf = 0; ne = 0; first = -1; hold_bad = 0;
    for (int i = 1; i <= r.cyc; i++) begin
      step(r.b, r.hab, r.rst);
      if (fez_jogada === 1'b1) begin
        nf++;
        if (first < 0) first = i;
      end else if (nf > 0 && r.b != '0 && db_estado !== 2'd0) begin
        hold_bad++;
      end
      if (erro_multipla === 1'b1) ne++;
    end
    check($sformatf("row%0d_fez_count", idx), 32'(nf), 32'(r.n_fez));
    check($sformatf("row%0d_erro_count", idx), 32'(ne), 32'(r.n_err));
    if (r.first_fez >= 0)
      check($sformatf("row%0d_latency", idx), 32'(first), 32'(r.first_fez));
    check($sformatf("row%0d_jogada", idx), 32'(jogada), 32'(r.jog));
    check($sformatf("row%0d_estado", idx), 32'(db_estado), 32'(r.est));
    check($sformatf("row%0d_hold_estado", idx), 32'(hold_bad), 32'd0);
  endtask

  initial begin
    int nf, ne;
    logic [NB-1:0] v;
    logic          h;
    int            len, kind;

    reset = 1'b1; botoes = '0; habilita = 1'b0;
    m_d1 = '0; m_d2 = '0; m_armed = 1'b0; m_quiet = 0; m_run = 0;
    m_val = '0; m_jog = '0; m_emit = 1'b0; m_err = 1'b0;

    //            rst   hab   botoes  cyc fez err first jogada  estado
    rows.push_back('{1'b1, 1'b0, 4'b0000,   2, 0, 0, -1, 4'b0000, 2'd0}); // 0 reset
    rows.push_back('{1'b0, 1'b0, 4'b0000,   8, 0, 0, -1, 4'b0000, 2'd1}); // 1 idle
    rows.push_back('{1'b0, 1'b1, 4'b0100,  20, 1, 0,  7, 4'b0100, 2'd0}); // 2 clean press
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b0100, 2'd1}); // 3 release
    rows.push_back('{1'b0, 1'b1, 4'b0001,  10, 1, 0,  7, 4'b0001, 2'd0}); // 4 second press
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b0001, 2'd1}); // 5 release
    rows.push_back('{1'b0, 1'b1, 4'b0011,  10, 0, 1, -1, 4'b0001, 2'd0}); // 6 chord
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b0001, 2'd1}); // 7 release
    rows.push_back('{1'b0, 1'b0, 4'b1000,  10, 0, 0, -1, 4'b0001, 2'd1}); // 8 gated press
    rows.push_back('{1'b0, 1'b1, 4'b1000,   8, 1, 0,  5, 4'b1000, 2'd0}); // 9 enable rises
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b1000, 2'd1}); // 10 release
    rows.push_back('{1'b0, 1'b1, 4'b0100,   4, 0, 0, -1, 4'b1000, 2'd2}); // 11 into filter
    rows.push_back('{1'b0, 1'b0, 4'b0100,   6, 0, 0, -1, 4'b1000, 2'd1}); // 12 enable drops
    rows.push_back('{1'b0, 1'b0, 4'b0000,   4, 0, 0, -1, 4'b1000, 2'd1}); // 13 release
    rows.push_back('{1'b0, 1'b1, 4'b0010,   4, 0, 0, -1, 4'b1000, 2'd2}); // 14 into filter
    rows.push_back('{1'b1, 1'b1, 4'b0010,   1, 0, 0, -1, 4'b0000, 2'd0}); // 15 reset in filter
    rows.push_back('{1'b0, 1'b1, 4'b0010,  12, 0, 0, -1, 4'b0000, 2'd0}); // 16 held past reset
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b0000, 2'd1}); // 17 release
    rows.push_back('{1'b0, 1'b1, 4'b0100,  10, 1, 0,  7, 4'b0100, 2'd0}); // 18 re-press
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b0100, 2'd1}); // 19 release
    rows.push_back('{1'b0, 1'b1, 4'b0001, 100, 1, 0,  7, 4'b0001, 2'd0}); // 20 long hold
    rows.push_back('{1'b0, 1'b1, 4'b0000,   8, 0, 0, -1, 4'b0001, 2'd1}); // 21 release

    for (int i = 0; i < 20; i++) apply_row(rows[i], i);

    // Bounce: 1-on/1-off six times, then a stable hold.
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0010, 1'b1, 1'b0);
      if (fez_jogada === 1'b1) nf++;
      step(4'b0000, 1'b1, 1'b0);
      if (fez_jogada === 1'b1) nf++;
    end
    check("bounce_no_strobe", 32'(nf), 32'd0);
    nf = 0; ne = -1;
    for (int i = 1; i <= 12; i++) begin
      step(4'b0010, 1'b1, 1'b0);
      if (fez_jogada === 1'b1) begin
        nf++;
        if (ne < 0) ne = i;
      end
    end
    check("bounce_strobe_count", 32'(nf), 32'd1);
    check("bounce_latency", 32'(ne), 32'd7);
    check("bounce_jogada", 32'(jogada), 32'(4'b0010));
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b0);
    check("bounce_release_estado", 32'(db_estado), 32'd1);

    for (int i = 20; i < 22; i++) apply_row(rows[i], i);

    // Randomized traffic checked cycle by cycle against the model.
    for (int seg = 0; seg < 220; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        step('0, 1'b0, 1'b1);
      end
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 14));
      h    = ($urandom_range(0, 9) < 8);
      if (kind <= 2)      v = '0;
      else if (kind <= 6) v = NB'(1) << $urandom_range(0, NB - 1);
      else if (kind == 7) v = NB'($urandom);
      else                v = (NB'(1) << $urandom_range(0, 1)) | (NB'(1) << $urandom_range(2, NB - 1));
      for (int c = 0; c < len; c++) begin
        if (kind == 8) step((c % 2 == 0) ? v : '0, h, 1'b0);
        else           step(v, h, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
